spike_detector: RTL and testbench
=================================

// Module: spike_detector
// PURPOSE
//  Per-channel negative threshold-crossing detector with refractory lockout. Sits directly
//  downstream of the channel-interleaved biquad filter and consumes its filtered
//  (channel, data, valid, last) stream. Emits spike events {channel, frame timestamp, sample}
//  through a small FIFO on a ready/valid stream toward the waveform-capture/sorting stage.
// PARAMETERS
//  FIFO_DEPTH   16   event FIFO entries; power of two, >=2
//  TIME_WIDTH   32   frame timestamp width; wraps modulo 2**TIME_WIDTH
//  REFRACTORY   30   samples of the same channel ignored after a detection; >=1
//  (local) REFR_W = $clog2(REFRACTORY+1)
// PORTS
//  clk                 in   1               system clock
//  rst_n               in   1               async active-low reset
//  cfg_threshold       in   DATA_WIDTH      signed threshold (data_t), quasi-static
//  s_axis_a_tchannel   in   channel_t       channel of input sample
//  s_axis_a_tdata      in   DATA_WIDTH      filtered sample, signed
//  s_axis_a_tvalid     in   1               sample strobe (no backpressure upstream)
//  s_axis_a_tlast      in   1               last channel of a frame
//  m_axis_b_tchannel   out  channel_t       event channel
//  m_axis_b_ttime      out  TIME_WIDTH      frame index of the crossing sample
//  m_axis_b_tdata      out  DATA_WIDTH      crossing sample value
//  m_axis_b_tvalid     out  1               event available
//  m_axis_b_tready     in   1               consumer accepts event
//  overflow            out  1               sticky: an event was dropped
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; frame counter 0; per-channel below[]=0, refr[]=0;
//   FIFO emptied. Reset mid-operation drops queued events and any in-flight sample.
//  Input accepted every cycle with s_axis_a_tvalid=1; no stalls, no ready.
//  Per sample on channel c (all decisions use state before the edge):
//   below_now = $signed(tdata) < $signed(cfg_threshold)
//   detect    = below_now && !below[c] && refr[c]==0
//   below[c] <= below_now (always updated)
//   refr[c]  <= detect ? REFRACTORY : (refr[c]!=0 ? refr[c]-1 : 0)
//  Per-channel state held in register arrays, read and written in the same cycle, so
//   back-to-back samples of one channel (CHANNEL_COUNT=1) see correct state without forwarding.
//  Refractory expiry while still below threshold does not fire; re-arm needs a sample >= threshold.
//  Frame counter: event uses current value; increments after any valid sample with tlast=1.
//   Wraps from 2**TIME_WIDTH-1 to 0 with no flag.
//  Pipeline: detect registered into event reg (cycle N+1), written to FIFO at N+1 edge;
//   with empty FIFO m_axis_b_tvalid rises at cycle N+2 (latency 2 cycles).
//  Output handshake: transfer when tvalid&&tready; tvalid/tchannel/ttime/tdata stable while
//   tvalid=1 and tready=0. Show-ahead FIFO head drives outputs.
//  FIFO full: write accepted if !full OR a read occurs in the same cycle; otherwise event
//   dropped and overflow<=1 (stays 1 until reset). Empty: tvalid=0, reads ignored.
//  Simultaneous read+write at any occupancy: count unchanged, order preserved.
// STRUCTURE
//  conf_pkg additions: TIME_WIDTH, REFRACTORY defaults; typedef time_t; typedef struct packed
//   {channel_t channel; time_t time; data_t data;} spike_event_t.
//  Sub-module: event_fifo (sync show-ahead FIFO of spike_event_t, params DEPTH; ports
//   wr_en/din/full, rd_en/dout/empty). Detector logic and frame counter in this module.
// TESTING
//  1 ch3 samples 0,-50,-120,-130 thr=-100, tready=1 -> one event {3,t,-120} 2 cycles after
//    -120 sample; no event for -130.
//  2 REFRACTORY=4, ch0 crosses, recovers to 0, crosses again at 3rd later sample -> 2nd
//    suppressed; crossing at 5th later sample after re-arm -> event.
//  3 4 channels interleaved, tlast on ch3, frame counter preloaded via 2**TIME_WIDTH-1 frames
//    (TIME_WIDTH=4) -> event ttime 15 then 0 after wrap; channels' state independent.
//  4 tready=0, 17 crossings with FIFO_DEPTH=16 -> 16 held in order, 17th dropped,
//    overflow=1; then tready=1 drains exactly 16 events, overflow stays 1.
//  5 FIFO full and tready=1 in same cycle as new event -> event accepted, no overflow.
//  6 rst_n pulsed low mid-burst with 5 queued -> tvalid=0 immediately, ttime of next event 0,
//    first crossing after reset detected.

Source files
------------

// File: rtl/spike_detector_pkg.sv
//==============================================================================
// Module   : spike_detector_pkg
// Brief    : Shared widths, types and parameter defaults for the spike detector.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

package spike_detector_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int CHANNEL_COUNT  = 4;
    localparam int CHANNEL_WIDTH  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;

    localparam int TIME_WIDTH_DEF = 32;
    localparam int REFRACTORY_DEF = 30;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef logic        [CHANNEL_WIDTH-1:0]  channel_t;
    typedef logic signed [DATA_WIDTH-1:0]     data_t;
    typedef logic        [TIME_WIDTH_DEF-1:0] time_t;

    // "time" is reserved in SystemVerilog, hence the member name timestamp
    typedef struct packed {
        channel_t channel;
        time_t    timestamp;
        data_t    data;
    } spike_event_t;

endpackage

`default_nettype wire

// File: rtl/spike_detector_if.sv
//==============================================================================
// Module   : spike_sample_if / spike_event_if
// Brief    : Filtered-sample input stream and spike-event output stream.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

interface spike_sample_if
    import spike_detector_pkg::*;
;
    channel_t tchannel;
    data_t    tdata;
    logic     tvalid;
    logic     tlast;

    modport master (output tchannel, output tdata, output tvalid, output tlast);
    modport slave  (input  tchannel, input  tdata, input  tvalid, input  tlast);
endinterface

interface spike_event_if
    import spike_detector_pkg::*;
#(
    parameter int TIME_WIDTH = TIME_WIDTH_DEF
);
    channel_t              tchannel;
    logic [TIME_WIDTH-1:0] ttime;
    data_t                 tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tchannel, output ttime, output tdata, output tvalid, input  tready);
    modport slave  (input  tchannel, input  ttime, input  tdata, input  tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/spike_detector_event_fifo.sv
//==============================================================================
// Module   : event_fifo
// Brief    : Synchronous show-ahead FIFO; head entry is always visible on dout.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] din,
    output logic                  full,
    input  wire logic             rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;
    logic             w_wr;

    // A read in the same cycle frees the slot, so a full FIFO still accepts a write
    always_comb begin
        w_rd = rd_en && (r_count != '0);
        w_wr = wr_en && ((r_count != CW'(DEPTH)) || w_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/spike_detector.sv
//==============================================================================
// Module   : spike_detector
// Brief    : Per-channel negative threshold-crossing detector with refractory
//            lockout, frame timestamping and a buffered event stream.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module spike_detector
    import spike_detector_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int REFRACTORY = REFRACTORY_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire data_t      cfg_threshold,
    spike_sample_if.slave   s_axis_a,
    spike_event_if.master   m_axis_b,
    output logic            overflow
);
    localparam int REFR_W = $clog2(REFRACTORY + 1);
    localparam int EVT_W  = CHANNEL_WIDTH + TIME_WIDTH + DATA_WIDTH;

    logic                  r_below [CHANNEL_COUNT];
    logic [REFR_W-1:0]     r_refr  [CHANNEL_COUNT];
    logic [TIME_WIDTH-1:0] r_frame;
    logic                  r_evt_valid;
    logic [EVT_W-1:0]      r_evt;

    logic                  w_below_now;
    logic                  w_detect;
    logic                  w_full;
    logic                  w_empty;
    logic [EVT_W-1:0]      w_dout;

    always_comb begin
        w_below_now = $signed(s_axis_a.tdata) < $signed(cfg_threshold);
        w_detect    = s_axis_a.tvalid && w_below_now
                      && !r_below[s_axis_a.tchannel]
                      && (r_refr[s_axis_a.tchannel] == '0);
    end

    // Per-channel arm/lockout state; only the addressed channel moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                r_below[i] <= 1'b0;
                r_refr[i]  <= '0;
            end
        end else if (s_axis_a.tvalid) begin
            r_below[s_axis_a.tchannel] <= w_below_now;
            if (w_detect)
                r_refr[s_axis_a.tchannel] <= REFR_W'(REFRACTORY);
            else if (r_refr[s_axis_a.tchannel] != '0)
                r_refr[s_axis_a.tchannel] <= r_refr[s_axis_a.tchannel] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame     <= '0;
            r_evt_valid <= 1'b0;
            r_evt       <= '0;
            overflow    <= 1'b0;
        end else begin
            if (s_axis_a.tvalid && s_axis_a.tlast)
                r_frame <= r_frame + 1'b1;
            r_evt_valid <= w_detect;
            if (w_detect)
                r_evt <= {s_axis_a.tchannel, r_frame, s_axis_a.tdata};
            // Full implies non-empty, so tready alone tells whether a slot frees up
            if (r_evt_valid && w_full && !m_axis_b.tready)
                overflow <= 1'b1;
        end
    end

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (r_evt_valid),
        .din   (r_evt),
        .full  (w_full),
        .rd_en (m_axis_b.tready),
        .dout  (w_dout),
        .empty (w_empty)
    );

    assign m_axis_b.tvalid = !w_empty;
    assign {m_axis_b.tchannel, m_axis_b.ttime, m_axis_b.tdata} = w_empty ? '0 : w_dout;

endmodule

`default_nettype wire

// File: tb/tb_spike_detector.sv
//==============================================================================
// Module   : tb_spike_detector
// Brief    : Directed self-checking bench for spike_detector.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_spike_detector;
    import spike_detector_pkg::*;

    localparam int TW = 4;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    data_t thr;
    logic  overflow;
    int    n_vec = 0;
    int    n_err = 0;
    logic [21:0] q[$];

    spike_sample_if                   a ();
    spike_event_if #(.TIME_WIDTH(TW)) b ();

    spike_detector #(
        .FIFO_DEPTH (16),
        .TIME_WIDTH (TW),
        .REFRACTORY (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_threshold (thr),
        .s_axis_a      (a),
        .m_axis_b      (b),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Accepted events: a handshake seen at the falling edge completes at the next rising edge
    always @(negedge clk) begin
        if (b.tvalid && b.tready) q.push_back({b.tchannel, b.ttime, b.tdata});
    end

    function automatic logic [21:0] ev(input int ch, input int t, input int d);
        return {2'(ch), 4'(t), 16'(d)};
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [21:0] exp);
        logic [21:0] v;
        v = 'x;
        if (q.size() > 0) v = q.pop_front();
        n_vec++;
        assert (v === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, v, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int d, input bit last);
        a.tchannel = channel_t'(ch);
        a.tdata    = data_t'(d);
        a.tlast    = last;
        a.tvalid   = 1'b1;
        @(posedge clk);
        #1;
        a.tvalid   = 1'b0;
        a.tlast    = 1'b0;
    endtask

    // Round-robin over 4 channels; each channel crosses every 5th round so the
    // 4-sample lockout has expired and the channel re-armed. Event k carries -150-k.
    task automatic crossings(input int n);
        int k;
        k = 0;
        for (int r = 0; k < n; r++) begin
            for (int c = 0; c < 4 && k < n; c++) begin
                if (r % 5 == 0) begin
                    send(c, -150 - k, 1'b0);
                    k++;
                end else begin
                    send(c, 0, 1'b0);
                end
            end
        end
    endtask

    task automatic do_reset();
        a.tvalid = 1'b0;
        a.tlast  = 1'b0;
        b.tready = 1'b0;
        rst_n    = 1'b0;
        idle(2);
        rst_n    = 1'b1;
        idle(1);
        q.delete();
    endtask

    initial begin
        thr        = -16'sd100;
        a.tchannel = '0;
        a.tdata    = '0;
        a.tvalid   = 1'b0;
        a.tlast    = 1'b0;
        b.tready   = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_tvalid",   longint'(b.tvalid),   0);
        chk("rst_overflow", longint'(overflow),   0);
        chk("rst_tchannel", longint'(b.tchannel), 0);
        chk("rst_ttime",    longint'(b.ttime),    0);
        chk("rst_tdata",    longint'(b.tdata),    0);

        // 1: single crossing, latency 2, no re-fire while still below
        b.tready = 1'b1;
        send(3, 0, 1'b0);
        send(3, -50, 1'b0);
        send(3, -120, 1'b0);
        @(negedge clk);
        chk("t1_lat1_tvalid", longint'(b.tvalid), 0);
        send(3, -130, 1'b0);
        @(negedge clk);
        chk("t1_lat2_tvalid",   longint'(b.tvalid),   1);
        chk("t1_lat2_tchannel", longint'(b.tchannel), 3);
        chk("t1_lat2_tdata",    longint'(b.tdata),    -120);
        idle(4);
        chk("t1_count", q.size(), 1);
        pop_chk("t1_evt", ev(3, 0, -120));

        // 2: refractory lockout and re-arm; expiry while below does not fire
        do_reset();
        b.tready = 1'b1;
        send(0, -150, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, -160, 1'b0);
        send(0, 0, 1'b0);
        send(0, -170, 1'b0);
        send(1, -180, 1'b0);
        for (int i = 1; i <= 5; i++) send(1, -180 - i, 1'b0);
        send(1, 0, 1'b0);
        send(1, -190, 1'b0);
        idle(5);
        chk("t2_count", q.size(), 4);
        pop_chk("t2_evt0", ev(0, 0, -150));
        pop_chk("t2_evt1", ev(0, 0, -170));
        pop_chk("t2_evt2", ev(1, 0, -180));
        pop_chk("t2_evt3", ev(1, 0, -190));

        // 3: interleaved channels, timestamp wrap 15 -> 0
        do_reset();
        b.tready = 1'b1;
        repeat (15) for (int c = 0; c < 4; c++) send(c, 0, c == 3);
        send(0, 0, 1'b0);
        send(1, -200, 1'b0);
        send(2, -300, 1'b0);
        send(3, 0, 1'b1);
        send(0, -110, 1'b0);
        send(1, -200, 1'b0);
        send(2, 0, 1'b0);
        send(3, 0, 1'b1);
        idle(5);
        chk("t3_count", q.size(), 3);
        pop_chk("t3_evt0", ev(1, 15, -200));
        pop_chk("t3_evt1", ev(2, 15, -300));
        pop_chk("t3_evt2", ev(0, 0, -110));

        // 4: overflow with a stalled consumer, then drain
        do_reset();
        crossings(17);
        idle(4);
        @(negedge clk);
        chk("t4_overflow", longint'(overflow), 1);
        chk("t4_tvalid",   longint'(b.tvalid), 1);
        chk("t4_head",     longint'(b.tdata),  -150);
        idle(3);
        @(negedge clk);
        chk("t4_hold_tdata",    longint'(b.tdata),    -150);
        chk("t4_hold_tchannel", longint'(b.tchannel), 0);
        b.tready = 1'b1;
        idle(25);
        chk("t4_count", q.size(), 16);
        for (int k = 0; k < 16; k++) pop_chk($sformatf("t4_evt%0d", k), ev(k % 4, 0, -150 - k));
        chk("t4_overflow_sticky", longint'(overflow), 1);
        chk("t4_empty",           longint'(b.tvalid), 0);

        // 5: write into a full FIFO in the same cycle as a read
        do_reset();
        crossings(17);
        b.tready = 1'b1;
        idle(1);
        b.tready = 1'b0;
        @(negedge clk);
        chk("t5_overflow", longint'(overflow), 0);
        b.tready = 1'b1;
        idle(25);
        chk("t5_count", q.size(), 17);
        for (int k = 0; k < 17; k++) pop_chk($sformatf("t5_evt%0d", k), ev(k % 4, 0, -150 - k));
        chk("t5_overflow_end", longint'(overflow), 0);

        // 6: async reset with events queued
        do_reset();
        repeat (3) send(3, 0, 1'b1);
        crossings(5);
        idle(4);
        @(negedge clk);
        chk("t6_pre_tvalid", longint'(b.tvalid), 1);
        chk("t6_pre_ttime",  longint'(b.ttime),  3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", longint'(b.tvalid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        b.tready = 1'b1;
        send(2, -150, 1'b0);
        idle(5);
        chk("t6_count", q.size(), 1);
        pop_chk("t6_evt", ev(2, 0, -150));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
